// File: rtl/sram_banked_ctrl.sv
// Multi-bank SRAM front end: decodes the bank from the upper address bits, drives one
// single-port macro per access and returns read data through a valid/ready response FIFO.
module sram_banked_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_BANKS  = 4,
  parameter int NUM_WMASK  = 0,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                                                       clk0,
  input  logic                                                       rst0_n,
  input  logic                                                       req_valid0,
  output logic                                                       req_ready0,
  input  logic [ADDR_WIDTH-1:0]                                      addr0,
  input  logic [DATA_WIDTH-1:0]                                      din0,
  input  logic                                                       web0,
  input  logic [((NUM_WMASK > 0) ? NUM_WMASK : 1)-1:0]               wmask0,
  output logic                                                       rsp_valid0,
  input  logic                                                       rsp_ready0,
  output logic [DATA_WIDTH-1:0]                                      dout0,
  output logic [NUM_BANKS-1:0]                                       bank_csb0,
  output logic [NUM_BANKS-1:0]                                       bank_web0,
  output logic [ADDR_WIDTH-((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0)-1:0] bank_addr0,
  output logic [DATA_WIDTH-1:0]                                      bank_din0,
  output logic [((NUM_WMASK > 0) ? NUM_WMASK : 1)-1:0]               bank_wmask0,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]                            bank_dout0
);

  localparam int BANK_SEL = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int BANK_W   = (BANK_SEL > 0) ? BANK_SEL : 1;
  localparam int WM_W     = (NUM_WMASK > 0) ? NUM_WMASK : 1;
  localparam int IN_AW    = ADDR_WIDTH - BANK_SEL;
  localparam int PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W    = $clog2(RSP_DEPTH + 1);
  localparam logic FULL_WORD = 1'(NUM_WMASK == 0);

  logic                  rst_done_q, rst_done_d;
  logic                  inflight_q, inflight_d;
  logic [BANK_W-1:0]     inflight_bank_q, inflight_bank_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];

  logic [BANK_W-1:0]     req_bank_s;
  logic                  fire_s;
  logic                  push_s;
  logic                  pop_s;
  logic [CNT_W:0]        occupancy_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  // Wrapping pointer increment so the FIFO depth need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RSP_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  generate
    if (BANK_SEL > 0) begin : g_multi_bank
      assign req_bank_s = addr0[ADDR_WIDTH-1 -: BANK_SEL];
    end else begin : g_single_bank
      assign req_bank_s = '0;
    end
  endgenerate

  // Outstanding reads are counted against the FIFO so a returning word always has a slot
  assign occupancy_s = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign req_ready0  = rst_done_q & (occupancy_s < (CNT_W + 1)'(RSP_DEPTH));
  assign fire_s      = req_valid0 & req_ready0;
  assign push_s      = inflight_q;
  assign rsp_valid0  = (count_q != '0);
  assign pop_s       = rsp_valid0 & rsp_ready0;
  assign dout0       = mem_q[rd_ptr_q];

  assign bank_addr0  = addr0[IN_AW-1:0];
  assign bank_din0   = din0;
  assign bank_wmask0 = wmask0 | {WM_W{FULL_WORD}};

  // Per-bank chip select and write enable for the accepted request only
  always_comb begin
    bank_csb0 = '1;
    bank_web0 = '1;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (fire_s && (req_bank_s == BANK_W'(i))) begin
        bank_csb0[i] = 1'b0;
        bank_web0[i] = web0;
      end else begin
        bank_csb0[i] = 1'b1;
        bank_web0[i] = 1'b1;
      end
    end
  end

  // Select the returning word from the bank that was read last cycle
  always_comb begin
    rd_data_s = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      rd_data_s = rd_data_s |
                  ((inflight_bank_q == BANK_W'(i)) ? bank_dout0[i*DATA_WIDTH +: DATA_WIDTH]
                                                   : {DATA_WIDTH{1'b0}});
    end
  end

  // Next-state for the read pipeline and FIFO bookkeeping
  always_comb begin
    rst_done_d      = 1'b1;
    inflight_d      = fire_s & web0;
    inflight_bank_d = inflight_bank_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    if (fire_s && web0) begin
      inflight_bank_d = req_bank_s;
    end else begin
      inflight_bank_d = inflight_bank_q;
    end
    if (push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset drops any in-flight read and all queued responses
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      rst_done_q      <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_bank_q <= '0;
      count_q         <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rst_done_q      <= rst_done_d;
      inflight_q      <= inflight_d;
      inflight_bank_q <= inflight_bank_d;
      count_q         <= count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= rd_data_s;
      end
    end
  end

endmodule

// File: tb/tb_sram_banked_ctrl.sv
// Scoreboard bench for sram_banked_ctrl: a 4-bank masked instance and a 1-bank instance,
// each behind behavioural single-port macros.
module tb_sram_banked_ctrl;

  logic clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  logic        rst0_n, req_valid0, web0, rsp_ready0;
  logic [5:0]  addr0;
  logic [7:0]  din0;
  logic [1:0]  wmask0;
  logic        req_ready0, rsp_valid0;
  logic [7:0]  dout0;
  logic [3:0]  bank_csb0, bank_web0, bank_addr0;
  logic [7:0]  bank_din0;
  logic [1:0]  bank_wmask0;
  logic [31:0] bank_dout0;

  logic        sb_req_valid0, sb_web0, sb_rsp_ready0, sb_req_ready0, sb_rsp_valid0;
  logic [5:0]  sb_addr0, sb_bank_addr0;
  logic [7:0]  sb_din0, sb_dout0, sb_bank_din0, sb_bdout;
  logic [0:0]  sb_wmask0, sb_bank_wmask0, sb_bank_csb0, sb_bank_web0;

  sram_banked_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .NUM_BANKS(4), .NUM_WMASK(2), .RSP_DEPTH(4)) u_dut (
    .clk0(clk0), .rst0_n(rst0_n), .req_valid0(req_valid0), .req_ready0(req_ready0),
    .addr0(addr0), .din0(din0), .web0(web0), .wmask0(wmask0),
    .rsp_valid0(rsp_valid0), .rsp_ready0(rsp_ready0), .dout0(dout0),
    .bank_csb0(bank_csb0), .bank_web0(bank_web0), .bank_addr0(bank_addr0),
    .bank_din0(bank_din0), .bank_wmask0(bank_wmask0), .bank_dout0(bank_dout0));

  sram_banked_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .NUM_BANKS(1), .NUM_WMASK(0), .RSP_DEPTH(4)) u_sb (
    .clk0(clk0), .rst0_n(rst0_n), .req_valid0(sb_req_valid0), .req_ready0(sb_req_ready0),
    .addr0(sb_addr0), .din0(sb_din0), .web0(sb_web0), .wmask0(sb_wmask0),
    .rsp_valid0(sb_rsp_valid0), .rsp_ready0(sb_rsp_ready0), .dout0(sb_dout0),
    .bank_csb0(sb_bank_csb0), .bank_web0(sb_bank_web0), .bank_addr0(sb_bank_addr0),
    .bank_din0(sb_bank_din0), .bank_wmask0(sb_bank_wmask0), .bank_dout0(sb_bdout));

  // Behavioural macros: latch on the select edge, read data valid the following cycle
  logic [7:0] bmem [4][16];
  logic [7:0] bdout [4];
  logic [7:0] sbmem [64];
  assign bank_dout0 = {bdout[3], bdout[2], bdout[1], bdout[0]};

  always @(posedge clk0) begin
    for (int b = 0; b < 4; b++) begin
      if (!bank_csb0[b]) begin
        if (!bank_web0[b]) begin
          if (bank_wmask0[0]) bmem[b][bank_addr0][3:0] <= bank_din0[3:0];
          if (bank_wmask0[1]) bmem[b][bank_addr0][7:4] <= bank_din0[7:4];
        end else begin
          bdout[b] <= bmem[b][bank_addr0];
        end
      end
    end
    if (!sb_bank_csb0[0]) begin
      if (!sb_bank_web0[0]) sbmem[sb_bank_addr0] <= sb_bank_din0;
      else sb_bdout <= sbmem[sb_bank_addr0];
    end
  end

  int n_checks = 0;
  int n_pass = 0;
  int ovf_seen = 0;
  logic [7:0] exp_q [$];
  logic [7:0] sb_exp_q [$];
  logic [7:0] mon_exp, sb_mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitors: compare every delivered response against the head of the expected queue
  always @(negedge clk0) begin
    if (rst0_n && rsp_valid0 && rsp_ready0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(dout0), 32'hDEAD);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rsp_data", 32'(dout0), 32'(mon_exp));
      end
    end
    if (rst0_n && sb_rsp_valid0 && sb_rsp_ready0) begin
      if (sb_exp_q.size() == 0) begin
        chk("sb_unexpected_rsp", 32'(sb_dout0), 32'hDEAD);
      end else begin
        sb_mon_exp = sb_exp_q.pop_front();
        chk("sb_rsp_data", 32'(sb_dout0), 32'(sb_mon_exp));
      end
    end
    if (u_dut.count_q > 3'd4) ovf_seen = 1;
  end

  int         w_d;
  logic [3:0] c_d, wb_d, a_d;
  logic [1:0] m_d;

  task automatic req(input logic [5:0] a, input logic [7:0] d, input logic w, input logic [1:0] m,
                     input logic [7:0] e, output int waits, output logic [3:0] csb,
                     output logic [3:0] wb, output logic [3:0] ba, output logic [1:0] bm);
    waits = 0;
    req_valid0 = 1'b1; addr0 = a; din0 = d; web0 = w; wmask0 = m;
    #1;
    while (!req_ready0 && waits < 60) begin
      @(posedge clk0); #2;
      waits++;
    end
    if (!req_ready0) chk("req_timeout", 32'(req_ready0), 32'd1);
    else if (w) exp_q.push_back(e);
    csb = bank_csb0; wb = bank_web0; ba = bank_addr0; bm = bank_wmask0;
    @(posedge clk0); #1;
    req_valid0 = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d, input logic [1:0] m);
    req(a, d, 1'b0, m, 8'h00, w_d, c_d, wb_d, a_d, m_d);
  endtask

  task automatic rd(input logic [5:0] a, input logic [7:0] e, output int waits);
    req(a, 8'h00, 1'b1, 2'b11, e, waits, c_d, wb_d, a_d, m_d);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || sb_exp_q.size() != 0) && n < 100) begin
      @(posedge clk0);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 32'(exp_q.size() + sb_exp_q.size()), 32'd0);
    #1;
  endtask

  task automatic sb_req(input logic w, input logic [7:0] d);
    int n = 0;
    sb_req_valid0 = 1'b1; sb_addr0 = 6'h3F; sb_din0 = d; sb_web0 = w;
    #1;
    while (!sb_req_ready0 && n < 20) begin
      @(posedge clk0); #2;
      n++;
    end
    chk("sb_ready", 32'(sb_req_ready0), 32'd1);
    chk("sb_csb", 32'(sb_bank_csb0), 32'd0);
    chk("sb_web", 32'(sb_bank_web0), 32'(w));
    chk("sb_addr", 32'(sb_bank_addr0), 32'h3F);
    chk("sb_wmask_ones", 32'(sb_bank_wmask0), 32'd1);
    if (w) sb_exp_q.push_back(8'h5C);
    @(posedge clk0); #1;
    sb_req_valid0 = 1'b0;
  endtask

  logic [5:0] st_a [4] = '{6'h00, 6'h10, 6'h20, 6'h30};
  logic [7:0] st_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [5:0] bp_a [6] = '{6'h03, 6'h17, 6'h2B, 6'h3C, 6'h0E, 6'h21};
  logic [7:0] bp_d [6] = '{8'h5A, 8'hC3, 8'h96, 8'h0F, 8'hE1, 8'h7B};
  int waits, bp_waits, stall5;
  logic [3:0] csb, wb, ba;
  logic [1:0] bm;

  initial begin
    rst0_n = 1'b0; req_valid0 = 1'b1; addr0 = 6'h25; din0 = 8'hA5; web0 = 1'b0; wmask0 = 2'b11;
    rsp_ready0 = 1'b1;
    sb_req_valid0 = 1'b0; sb_addr0 = 6'h00; sb_din0 = 8'h00; sb_web0 = 1'b1; sb_wmask0 = 1'b0;
    sb_rsp_ready0 = 1'b1;
    stall5 = 0;

    repeat (3) @(posedge clk0);
    #2;
    chk("rst_req_ready", 32'(req_ready0), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid0), 32'd0);
    chk("rst_dout", 32'(dout0), 32'd0);
    chk("rst_csb", 32'(bank_csb0), 32'hF);
    chk("rst_web", 32'(bank_web0), 32'hF);
    req_valid0 = 1'b0;
    @(negedge clk0);
    rst0_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(req_ready0), 32'd0);
    @(posedge clk0); #1;
    chk("ready_after_edge", 32'(req_ready0), 32'd1);

    // Write then read 0x25 (bank 2, in-bank address 5)
    req(6'h25, 8'hA5, 1'b0, 2'b11, 8'h00, waits, csb, wb, ba, bm);
    chk("wr_csb", 32'(csb), 32'b1011);
    chk("wr_web", 32'(wb), 32'b1011);
    chk("wr_addr", 32'(ba), 32'h5);
    #1;
    chk("idle_csb", 32'(bank_csb0), 32'hF);
    req(6'h25, 8'h00, 1'b1, 2'b11, 8'hA5, waits, csb, wb, ba, bm);
    chk("rd_csb", 32'(csb), 32'b1011);
    chk("rd_web", 32'(wb), 32'hF);
    @(negedge clk0);
    chk("rd_lat_t1", 32'(rsp_valid0), 32'd0);
    @(negedge clk0);
    chk("rd_lat_t2", 32'(rsp_valid0), 32'd1);
    chk("rd_dout", 32'(dout0), 32'hA5);
    drain();

    // Streaming reads across all four banks
    for (int i = 0; i < 4; i++) wr(st_a[i], st_d[i], 2'b11);
    for (int i = 0; i < 4; i++) begin
      rd(st_a[i], st_d[i], waits);
      chk("stream_ready", 32'(waits), 32'd0);
    end
    drain();

    // Backpressure: six reads against a four-entry FIFO
    for (int i = 0; i < 6; i++) wr(bp_a[i], bp_d[i], 2'b11);
    rsp_ready0 = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          rd(bp_a[i], bp_d[i], bp_waits);
          if (i == 4) stall5 = bp_waits;
        end
      end
      begin
        repeat (8) @(posedge clk0);
        #3;
        chk("bp_ready_low", 32'(req_ready0), 32'd0);
        chk("bp_valid", 32'(rsp_valid0), 32'd1);
        chk("bp_dout_head", 32'(dout0), 32'h5A);
        repeat (3) @(posedge clk0);
        #3;
        chk("bp_dout_stable", 32'(dout0), 32'h5A);
        rsp_ready0 = 1'b1;
      end
    join
    chk("bp_5th_stalled", 32'(stall5 > 0), 32'd1);
    drain();

    // Segment masks on bank 0, in-bank address 0xA
    wr(6'h0A, 8'hFF, 2'b11);
    req(6'h0A, 8'h00, 1'b0, 2'b01, 8'h00, waits, csb, wb, ba, bm);
    chk("wmask_drive", 32'(bm), 32'b01);
    rd(6'h0A, 8'hF0, waits);
    wr(6'h0A, 8'h3C, 2'b10);
    rd(6'h0A, 8'h30, waits);
    drain();

    // Reset while two responses are queued
    rsp_ready0 = 1'b0;
    rd(6'h03, 8'h5A, waits);
    rd(6'h17, 8'hC3, waits);
    repeat (2) @(posedge clk0);
    #2;
    chk("pre_rst_valid", 32'(rsp_valid0), 32'd1);
    chk("pre_rst_count", 32'(u_dut.count_q), 32'd2);
    rst0_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(rsp_valid0), 32'd0);
    chk("rst_async_dout", 32'(dout0), 32'd0);
    chk("rst_async_ready", 32'(req_ready0), 32'd0);
    exp_q.delete();
    rsp_ready0 = 1'b1;
    @(negedge clk0);
    rst0_n = 1'b1;
    repeat (3) @(posedge clk0);
    #2;
    chk("post_rst_empty", 32'(rsp_valid0), 32'd0);
    rd(6'h17, 8'hC3, waits);
    drain();

    // Single-bank instance: full address reaches the macro, same 2-cycle latency
    sb_req(1'b0, 8'h5C);
    sb_req(1'b1, 8'h00);
    @(negedge clk0);
    chk("sb_lat_t1", 32'(sb_rsp_valid0), 32'd0);
    @(negedge clk0);
    chk("sb_lat_t2", 32'(sb_rsp_valid0), 32'd1);
    drain();

    chk("queue_empty", 32'(exp_q.size() + sb_exp_q.size()), 32'd0);
    chk("no_overflow", 32'(ovf_seen), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_banked_ctrl.md
Name: sram_banked_ctrl

Overview:
Parametrised multi-bank SRAM controller placed in front of NUM_BANKS single-port macros of the sram_1bank kind. It decodes the upper address bits to a bank, drives one bank per access, and supports per-byte/segment write masks. It returns read data through a valid/ready response channel with a response FIFO, so downstream backpressure does not lose data. This replaces the fixed 2-bank combinational bank-select wrapper for larger, multi-bank arrays.

Parameters:
DATA_WIDTH, 32, word width in bits.
ADDR_WIDTH, 10, total word-address width, bank-select bits included.
NUM_BANKS, 4, number of banks; power of two, 1..16; BANK_SEL = log2(NUM_BANKS), 0 when NUM_BANKS=1.
NUM_WMASK, 0, write-mask segments; 0 = full-word writes only; otherwise DATA_WIDTH % NUM_WMASK == 0.
RSP_DEPTH, 4, response FIFO entries; minimum 2; 3 or more gives full read throughput.

Ports:
clk0  in  1  clock; all state on posedge
rst0_n  in  1  asynchronous active-low reset
req_valid0  in  1  request valid
req_ready0  out  1  request accepted when valid&ready
addr0  in  ADDR_WIDTH  word address; [ADDR_WIDTH-1 -: BANK_SEL] selects the bank
din0  in  DATA_WIDTH  write data
web0  in  1  0 = write, 1 = read
wmask0  in  max(NUM_WMASK,1)  segment enables; ignored when NUM_WMASK=0
rsp_valid0  out  1  read data valid
rsp_ready0  in  1  response consumed when valid&ready
dout0  out  DATA_WIDTH  read data, head of FIFO
bank_csb0  out  NUM_BANKS  per-bank chip select, active low
bank_web0  out  NUM_BANKS  per-bank write enable, active low
bank_addr0  out  ADDR_WIDTH-BANK_SEL  shared in-bank address
bank_din0  out  DATA_WIDTH  shared write data
bank_wmask0  out  max(NUM_WMASK,1)  shared mask; all ones when NUM_WMASK=0
bank_dout0  in  NUM_BANKS*DATA_WIDTH  bank read data; bank i in slice [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (rst0_n low, asynchronous):
  - rsp_valid0=0, dout0=0, FIFO empty, in-flight flag cleared.
  - req_ready0=0; all bank_csb0 and bank_web0 bits = 1.
  - A request or response in progress at reset is dropped.
  - After rst0_n rises, req_ready0 may go high no earlier than the first clock edge.
- Accept: fire = req_valid0 & req_ready0.
- Bank drive (combinational from fire):
  - Selected bank b: bank_csb0[b] = 0; bank_web0[b] = web0.
  - All other banks: csb = 1, web = 1.
  - bank_addr0 = addr0 low bits; bank_din0 = din0; bank_wmask0 = wmask0.
  - No fire means all csb and web = 1.
- Macro timing: the bank latches on the fire edge; bank_dout0 is valid during the following cycle.
- Read pipeline:
  - A read fire in cycle T sets inflight and records b (inflight_bank) at the T edge.
  - In T+1, the bank_dout0 slice for inflight_bank is pushed into the FIFO at the T+1 edge.
  - rsp_valid0 rises in T+2 when the FIFO was empty. Read latency is 2 cycles.
- Writes produce no response and do not occupy the FIFO.
- Flow control:
  - req_ready0 = rst0_n_synced & (count + inflight < RSP_DEPTH).
  - Registered terms only; no combinational path from rsp_ready0.
  - Writes also obey req_ready0.
- FIFO:
  - Push and pop in the same cycle keeps count.
  - Pop occurs only when rsp_valid0 & rsp_ready0.
  - dout0 and rsp_valid0 hold stable while rsp_ready0 is low.
  - Data is returned in request order.
  - Overflow is impossible by construction; the bench asserts count <= RSP_DEPTH.
- NUM_BANKS=1: bank index is constant 0 and bank_addr0 = addr0.
- Pointers wrap modulo RSP_DEPTH; RSP_DEPTH need not be a power of two.

Test Plan:
- Reset: hold rst0_n=0 with req_valid0=1 -> req_ready0=0, rsp_valid0=0, dout0=0, bank_csb0=4'b1111; deassert mid-read with 2 entries queued -> FIFO empty, rsp_valid0 drops asynchronously.
- Write/read (ADDR_WIDTH=6, DATA_WIDTH=8, NUM_BANKS=4): write 0x25 data 0xA5 -> bank_csb0=4'b1011, bank_web0=4'b1011, bank_addr0=0x5; read 0x25 at T -> rsp_valid0=1, dout0=0xA5 at T+2.
- Streaming: reads to 0x00,0x10,0x20,0x30 on consecutive cycles, rsp_ready0=1 -> req_ready0 stays 1; four consecutive responses in bank order 0,1,2,3.
- Backpressure: rsp_ready0=0, issue 6 reads -> req_ready0 low after 4 accepted; dout0 stable; raise rsp_ready0 -> 4 responses in order, then remaining 2 accepted.
- Write mask (NUM_WMASK=2): write 0xFF mask 2'b11, then 0x00 mask 2'b01 to the same address -> bank_wmask0=2'b01; readback 0xF0 with a masked bank model.
- Single bank (NUM_BANKS=1): address 0x3F read -> bank_csb0=1'b0, bank_addr0=0x3F, 2-cycle latency.
